// File: rtl/bambu_mem_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bambu_mem_channel_arbiter_if
// Description : Bundles the two-channel Mout_* request/response bus and the
//               shared single-port memory bus that surround the channel
//               arbiter.
//               slave  - arbiter view: channel requests and memory ack/rdata
//                        in; channel responses, memory request, grant and
//                        sticky error flags out.
//               master - environment view (HLS top plus memory), the mirror.
//               Channel vectors hold ch0 in the low slice, ch1 in the high.
// Revision    : 1.0 - initial release
// ============================================================================
interface bambu_mem_channel_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    // Channel side
    logic [1:0]          ch_oe;
    logic [1:0]          ch_we;
    logic [2*ADDR_W-1:0] ch_addr;
    logic [2*DATA_W-1:0] ch_wdata;
    logic [2*SIZE_W-1:0] ch_size;
    logic [2*DATA_W-1:0] ch_rdata;
    logic [1:0]          ch_datardy;
    // Memory side
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_mask;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    // Status
    logic [1:0]          grant;
    logic                err_both;
    logic                err_timeout;

    modport slave (
        input  ch_oe, ch_we, ch_addr, ch_wdata, ch_size, mem_ack, mem_rdata,
        output ch_rdata, ch_datardy, mem_req, mem_we, mem_addr, mem_wdata,
               mem_mask, grant, err_both, err_timeout
    );

    modport master (
        output ch_oe, ch_we, ch_addr, ch_wdata, ch_size, mem_ack, mem_rdata,
        input  ch_rdata, ch_datardy, mem_req, mem_we, mem_addr, mem_wdata,
               mem_mask, grant, err_both, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/bambu_mem_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bambu_mem_channel_arbiter
// Description : Shares one single-port memory between two Bambu master
//               channels. Accesses are serialized IDLE -> ISSUE -> RESP with
//               round-robin arbitration, a per-access watchdog, and sticky
//               flags for oe/we conflicts and watchdog aborts.
// Ports       : clock - rising-edge clock
//               reset - synchronous, active-high
//               bus   - bambu_mem_channel_arbiter_if.slave (channel requests,
//                       channel responses, memory port, grant, error flags)
// Revision    : 1.0 - initial release
// ============================================================================
module bambu_mem_channel_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    bambu_mem_channel_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    localparam int                c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    logic               r_owner;
    logic               r_last_grant;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_mask;
    logic [DATA_W-1:0]  r_rdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err_both;
    logic               r_err_timeout;

    logic [1:0]         w_valid;
    logic [1:0]         w_both;
    logic               w_any;
    logic               w_sel;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [SIZE_W-1:0]  w_sel_size;
    logic [DATA_W-1:0]  w_sel_mask;
    logic               w_expire;
    logic [1:0]         w_owner_onehot;

    // A channel request is valid only when exactly one of oe/we is set.
    assign w_valid = bus.ch_oe ^ bus.ch_we;
    assign w_both  = bus.ch_oe & bus.ch_we;
    assign w_any   = |w_valid;

    // Both valid: the channel that did not win last time. Otherwise the
    // single valid requester (ch1 only if it is the one asking).
    assign w_sel = (w_valid == 2'b11) ? ~r_last_grant : w_valid[1];

    assign w_sel_addr  = w_sel ? bus.ch_addr[2*ADDR_W-1:ADDR_W]   : bus.ch_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_sel ? bus.ch_wdata[2*DATA_W-1:DATA_W]  : bus.ch_wdata[DATA_W-1:0];
    assign w_sel_size  = w_sel ? bus.ch_size[2*SIZE_W-1:SIZE_W]   : bus.ch_size[SIZE_W-1:0];

    // Lane mask (1<<size)-1, saturating to all ones once size >= DATA_W.
    always_comb begin
        w_sel_mask = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w_sel_mask[b] = (int'(w_sel_size) > b);
        end
    end

    // Watchdog expiry only counts when the memory did not ack in that cycle.
    assign w_expire = (r_state == c_ISSUE) && !bus.mem_ack && (r_cnt == c_CNT_LAST);

    assign w_owner_onehot = r_owner ? 2'b10 : 2'b01;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_next_state = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (bus.mem_ack || w_expire) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: memory fields are only presented while issuing, and the
    // response appears for exactly the single RESP cycle.
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_mask   = '0;
        bus.grant      = 2'b00;
        bus.ch_datardy = 2'b00;
        bus.ch_rdata   = '0;
        case (r_state)
            c_ISSUE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_addr  = r_addr;
                bus.mem_wdata = r_wdata;
                bus.mem_mask  = r_mask;
                bus.grant     = w_owner_onehot;
            end
            c_RESP: begin
                bus.grant      = w_owner_onehot;
                bus.ch_datardy = w_owner_onehot;
                if (r_owner) begin
                    bus.ch_rdata[2*DATA_W-1:DATA_W] = r_rdata;
                end else begin
                    bus.ch_rdata[DATA_W-1:0] = r_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.err_both    = r_err_both;
    assign bus.err_timeout = r_err_timeout;

    // ------------------------------------------------------------------
    // Transaction latch, watchdog and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;   // ch0 wins the first tie
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_mask        <= '0;
            r_rdata       <= '0;
            r_cnt         <= '0;
            r_err_both    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == c_IDLE) begin
                if (|w_both) begin
                    r_err_both <= 1'b1;
                end
                if (w_any) begin
                    r_owner      <= w_sel;
                    r_last_grant <= w_sel;
                    r_we         <= w_sel ? bus.ch_we[1] : bus.ch_we[0];
                    r_addr       <= w_sel_addr;
                    r_wdata      <= w_sel_wdata;
                    r_mask       <= w_sel_mask;
                    r_rdata      <= '0;
                    r_cnt        <= '0;
                end
            end
            if (r_state == c_ISSUE) begin
                if (bus.mem_ack) begin
                    // Writes report zero data.
                    r_rdata <= r_we ? '0 : bus.mem_rdata;
                end else if (w_expire) begin
                    r_rdata       <= '0;
                    r_err_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bambu_mem_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bambu_mem_channel_arbiter
// Description : Directed self-checking bench for bambu_mem_channel_arbiter.
//               A small memory responder acks after a programmable delay;
//               expected channel responses are queued as requests are driven
//               and compared when ch_datardy pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bambu_mem_channel_arbiter;

    localparam int c_TIMEOUT = 4;

    typedef struct packed {
        logic       ch;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    logic [7:0] mem_arr [128];
    exp_t sb[$];

    bambu_mem_channel_arbiter_if #(.ADDR_W(7), .DATA_W(8), .SIZE_W(4)) bus ();

    bambu_mem_channel_arbiter #(
        .ADDR_W (7),
        .DATA_W (8),
        .SIZE_W (4),
        .TIMEOUT(c_TIMEOUT)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: ack after ack_delay ISSUE cycles, read data from model.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b0) begin
            if (wait_cnt >= ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_arr[bus.mem_addr];
                wait_cnt      = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
            wait_cnt      = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic oe, input logic we,
                          input logic [6:0] a, input logic [7:0] d, input logic [3:0] s);
        bus.ch_oe[ch]          = oe;
        bus.ch_we[ch]          = we;
        bus.ch_addr[ch*7 +: 7]  = a;
        bus.ch_wdata[ch*8 +: 8] = d;
        bus.ch_size[ch*4 +: 4]  = s;
    endtask

    task automatic clr();
        bus.ch_oe = 2'b00;
        bus.ch_we = 2'b00;
    endtask

    // Poll for a ch_datardy pulse, compare it against the scoreboard head,
    // then confirm the pulse lasts one cycle. Returns the cycle it was seen
    // and how many cycles mem_req was high (including the entry cycle).
    task automatic wait_rdy(input string tag, output int at_cyc, output int reqs);
        int   n;
        exp_t e;
        logic [7:0] slice;
        n      = 0;
        reqs   = (bus.mem_req === 1'b1) ? 1 : 0;
        at_cyc = -1;
        do begin
            @(negedge clk);
            n++;
            if (bus.mem_req === 1'b1) reqs++;
        end while (bus.ch_datardy === 2'b00 && n < 40);
        total++;
        assert (bus.ch_datardy !== 2'b00) else begin
            bad++;
            $error("FAIL %s_wait: observed datardy=%b expected a pulse within 40 cycles", tag, bus.ch_datardy);
            return;
        end
        at_cyc = cyc;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL %s_unexpected: observed datardy=%b expected no response", tag, bus.ch_datardy);
            return;
        end
        e     = sb.pop_front();
        slice = e.ch ? bus.ch_rdata[15:8] : bus.ch_rdata[7:0];
        check({tag, "_rdy"},   {30'd0, bus.ch_datardy}, e.ch ? 32'd2 : 32'd1);
        check({tag, "_grant"}, {30'd0, bus.grant},      e.ch ? 32'd2 : 32'd1);
        check({tag, "_rdata"}, {24'd0, slice},          {24'd0, e.data});
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, bus.ch_datardy}, 32'd0);
    endtask

    initial begin
        int c_drv;
        int at;
        int reqs;
        int t2_at [4];
        logic [1:0] seen;

        for (int i = 0; i < 128; i++) mem_arr[i] = 8'(i * 37 + 11);
        mem_arr[7'h05] = 8'hA5;
        mem_arr[7'h10] = 8'h11;
        mem_arr[7'h20] = 8'h22;
        mem_arr[7'h44] = 8'h4D;
        mem_arr[7'h21] = 8'h6E;

        rst           = 1'b1;
        bus.ch_oe     = 2'b00;
        bus.ch_we     = 2'b00;
        bus.ch_addr   = '0;
        bus.ch_wdata  = '0;
        bus.ch_size   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req",   {31'd0, bus.mem_req},     32'd0);
        check("rst_grant", {30'd0, bus.grant},       32'd0);
        check("rst_rdy",   {30'd0, bus.ch_datardy},  32'd0);
        check("rst_eboth", {31'd0, bus.err_both},    32'd0);
        check("rst_etmo",  {31'd0, bus.err_timeout}, 32'd0);
        rst = 1'b0;

        // T2: both channels read from reset, immediate ack -> alternate ch0,ch1
        ack_delay = 0;
        set_ch(0, 1'b1, 1'b0, 7'h10, 8'h00, 4'd8);
        set_ch(1, 1'b1, 1'b0, 7'h20, 8'h00, 4'd8);
        c_drv = cyc;
        sb.push_back('{ch: 1'b0, data: 8'h11});
        sb.push_back('{ch: 1'b1, data: 8'h22});
        sb.push_back('{ch: 1'b0, data: 8'h11});
        sb.push_back('{ch: 1'b1, data: 8'h22});
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wait_rdy("t2", at, reqs);
            t2_at[i] = at;
        end
        clr();
        check("t2_lat0", t2_at[0] - c_drv, 32'd2);
        check("t2_gap1", t2_at[1] - t2_at[0], 32'd3);
        check("t2_gap2", t2_at[2] - t2_at[1], 32'd3);
        check("t2_gap3", t2_at[3] - t2_at[2], 32'd3);

        // T1: ch0 read 0x05, ack two cycles after mem_req; size 15 saturates mask
        @(negedge clk);
        ack_delay = 2;
        set_ch(0, 1'b1, 1'b0, 7'h05, 8'h00, 4'd15);
        c_drv = cyc;
        sb.push_back('{ch: 1'b0, data: 8'hA5});
        @(negedge clk);
        clr();
        check("t1_req",   {31'd0, bus.mem_req},  32'd1);
        check("t1_we",    {31'd0, bus.mem_we},   32'd0);
        check("t1_grant", {30'd0, bus.grant},    32'd1);
        check("t1_addr",  {25'd0, bus.mem_addr}, 32'h05);
        check("t1_mask",  {24'd0, bus.mem_mask}, 32'hFF);
        wait_rdy("t1", at, reqs);
        check("t1_lat",  at - c_drv, 32'd4);
        check("t1_reqs", reqs,       32'd3);

        // T3: ch1 write 0x3C size 4
        ack_delay = 1;
        set_ch(1, 1'b0, 1'b1, 7'h33, 8'h3C, 4'd4);
        sb.push_back('{ch: 1'b1, data: 8'h00});
        @(negedge clk);
        clr();
        check("t3_req",   {31'd0, bus.mem_req},   32'd1);
        check("t3_we",    {31'd0, bus.mem_we},    32'd1);
        check("t3_mask",  {24'd0, bus.mem_mask},  32'h0F);
        check("t3_wdata", {24'd0, bus.mem_wdata}, 32'h3C);
        check("t3_addr",  {25'd0, bus.mem_addr},  32'h33);
        check("t3_grant", {30'd0, bus.grant},     32'd2);
        wait_rdy("t3", at, reqs);

        // T4: ch0 oe=we=1 while ch1 reads -> only ch1 served, err_both sticky
        ack_delay = 0;
        check("t4_eboth_pre", {31'd0, bus.err_both}, 32'd0);
        set_ch(0, 1'b1, 1'b1, 7'h01, 8'h00, 4'd8);
        set_ch(1, 1'b1, 1'b0, 7'h44, 8'h00, 4'd8);
        sb.push_back('{ch: 1'b1, data: 8'h4D});
        @(negedge clk);
        bus.ch_oe[1] = 1'b0;
        check("t4_eboth", {31'd0, bus.err_both}, 32'd1);
        check("t4_grant", {30'd0, bus.grant},    32'd2);
        wait_rdy("t4", at, reqs);
        seen = 2'b00;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.ch_datardy | bus.grant;
        end
        check("t4_ch0_idle", {30'd0, seen}, 32'd0);
        clr();
        check("t4_eboth_sticky", {31'd0, bus.err_both}, 32'd1);

        // T5b: ack in the fourth ISSUE cycle wins over the watchdog
        @(negedge clk);
        ack_delay = 3;
        set_ch(0, 1'b1, 1'b0, 7'h05, 8'h00, 4'd8);
        c_drv = cyc;
        sb.push_back('{ch: 1'b0, data: 8'hA5});
        @(negedge clk);
        clr();
        wait_rdy("t5b", at, reqs);
        check("t5b_reqs", reqs,       32'd4);
        check("t5b_lat",  at - c_drv, 32'd5);
        check("t5b_etmo", {31'd0, bus.err_timeout}, 32'd0);

        // T5: no ack -> mem_req high exactly TIMEOUT cycles, zero data, error
        ack_delay = 1000;
        set_ch(0, 1'b1, 1'b0, 7'h05, 8'h00, 4'd8);
        c_drv = cyc;
        sb.push_back('{ch: 1'b0, data: 8'h00});
        @(negedge clk);
        clr();
        wait_rdy("t5", at, reqs);
        check("t5_reqs", reqs,       c_TIMEOUT);
        check("t5_lat",  at - c_drv, c_TIMEOUT + 1);
        check("t5_etmo", {31'd0, bus.err_timeout}, 32'd1);

        // T6: reset during ISSUE -> immediate IDLE, no pulse, flags cleared
        ack_delay = 5;
        set_ch(0, 1'b1, 1'b0, 7'h05, 8'h00, 4'd8);
        @(negedge clk);
        clr();
        check("t6_req_pre", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_req",   {31'd0, bus.mem_req},     32'd0);
        check("t6_grant", {30'd0, bus.grant},       32'd0);
        check("t6_rdy",   {30'd0, bus.ch_datardy},  32'd0);
        check("t6_etmo",  {31'd0, bus.err_timeout}, 32'd0);
        check("t6_eboth", {31'd0, bus.err_both},    32'd0);
        rst = 1'b0;
        seen = 2'b00;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.ch_datardy;
        end
        check("t6_no_rdy", {30'd0, seen}, 32'd0);
        ack_delay = 0;
        set_ch(1, 1'b1, 1'b0, 7'h21, 8'h00, 4'd8);
        sb.push_back('{ch: 1'b1, data: 8'h6E});
        @(negedge clk);
        clr();
        wait_rdy("t6b", at, reqs);

        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
